hex_display_scheduler: RTL

Time-multiplexes the 32-bit value of the 8-digit hex display between up to NUM_SRC requesters. Its `val_out` drives the display controller's `val_in`, so one display shows pages from several subsystems in turn. Enabled sources rotate round-robin with a fixed dwell per page. A source can raise a one-shot alert that preempts the rotation for a fixed time.

---
 rtl/hex_display_scheduler.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/hex_display_scheduler.sv
// Shares one 8-digit hex display between NUM_SRC subsystems. Enabled sources
// rotate round-robin with a fixed dwell; one-shot alerts preempt the rotation.
module hex_display_scheduler #(
  parameter int NUM_SRC      = 4,
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int ALERT_CYCLES = 100_000_000,
  parameter int IDX_W        = $clog2(NUM_SRC)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [32*NUM_SRC-1:0] src_val_in,
  input  logic [NUM_SRC-1:0]    src_en_in,
  input  logic [NUM_SRC-1:0]    alert_in,
  input  logic                  hold_in,
  output logic [31:0]           val_out,
  output logic [IDX_W-1:0]      src_idx_out,
  output logic                  alert_active_out,
  output logic                  page_strobe_out
);

  localparam int DW_W = $clog2(DWELL_CYCLES + 1);
  localparam int AW_W = $clog2(ALERT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SHOW, ALERT} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   cur_idx_q, cur_idx_d, show_idx_d;
  logic [DW_W-1:0]    dwell_q, dwell_d;
  logic [AW_W-1:0]    alert_cnt_q, alert_cnt_d;
  logic [NUM_SRC-1:0] pending_q, pending_d, qual, req;
  logic               restart_d, rr_found, al_found;
  logic [IDX_W-1:0]   rr_win, al_win;
  logic [31:0]        val_d;

  // Search order is cur+1, cur+2, ... wrapping, ending at cur itself; iterating
  // backwards lets the earliest candidate in that order overwrite later ones.
  function automatic logic [IDX_W:0] rr_pick(input logic [IDX_W-1:0] cur,
                                             input logic [NUM_SRC-1:0] en);
    logic [IDX_W:0]   r;
    logic [IDX_W-1:0] jj;
    r = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      jj = IDX_W'((int'(cur) + k) % NUM_SRC);
      if (en[jj]) r = {1'b1, jj};
    end
    return r;
  endfunction

  function automatic logic [IDX_W:0] lowest_set(input logic [NUM_SRC-1:0] v);
    logic [IDX_W:0]   r;
    logic [IDX_W-1:0] ii;
    r = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      ii = IDX_W'(i);
      if (v[ii]) r = {1'b1, ii};
    end
    return r;
  endfunction

  always_comb begin
    qual                 = alert_in & src_en_in;
    req                  = pending_q | qual;
    {rr_found, rr_win}   = rr_pick(cur_idx_q, src_en_in);
    {al_found, al_win}   = lowest_set(req);
    state_d     = state_q;
    cur_idx_d   = cur_idx_q;
    show_idx_d  = src_idx_out;
    dwell_d     = dwell_q;
    alert_cnt_d = alert_cnt_q;
    pending_d   = req;
    restart_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (al_found) begin
          state_d           = ALERT;
          show_idx_d        = al_win;
          alert_cnt_d       = '0;
          pending_d[al_win] = 1'b0;
        end else if (rr_found) begin
          state_d    = SHOW;
          cur_idx_d  = rr_win;
          show_idx_d = rr_win;
          dwell_d    = '0;
        end
      end
      SHOW: begin
        if (al_found) begin
          state_d           = ALERT;
          show_idx_d        = al_win;
          alert_cnt_d       = '0;
          pending_d[al_win] = 1'b0;
        end else if (!src_en_in[cur_idx_q]) begin
          if (rr_found) begin
            cur_idx_d  = rr_win;
            show_idx_d = rr_win;
            dwell_d    = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (!hold_in) begin
          if (dwell_q == DW_W'(DWELL_CYCLES - 1)) begin
            cur_idx_d  = rr_win;
            show_idx_d = rr_win;
            dwell_d    = '0;
            restart_d  = 1'b1;
          end else begin
            dwell_d = dwell_q + DW_W'(1);
          end
        end
      end
      ALERT: begin
        if (alert_cnt_q == AW_W'(ALERT_CYCLES - 1)) begin
          restart_d = 1'b1;
          if (al_found) begin
            show_idx_d        = al_win;
            alert_cnt_d       = '0;
            pending_d[al_win] = 1'b0;
          end else if (src_en_in[cur_idx_q]) begin
            state_d    = SHOW;
            show_idx_d = cur_idx_q;
            dwell_d    = '0;
          end else if (rr_found) begin
            state_d    = SHOW;
            cur_idx_d  = rr_win;
            show_idx_d = rr_win;
            dwell_d    = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          alert_cnt_d = alert_cnt_q + AW_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) show_idx_d = '0;
    val_d = (state_d == IDLE) ? 32'd0 : src_val_in[{show_idx_d, 5'd0} +: 32];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q          <= IDLE;
      cur_idx_q        <= IDX_W'(NUM_SRC - 1);
      dwell_q          <= '0;
      alert_cnt_q      <= '0;
      pending_q        <= '0;
      val_out          <= '0;
      src_idx_out      <= '0;
      alert_active_out <= 1'b0;
      page_strobe_out  <= 1'b0;
    end else begin
      state_q          <= state_d;
      cur_idx_q        <= cur_idx_d;
      dwell_q          <= dwell_d;
      alert_cnt_q      <= alert_cnt_d;
      pending_q        <= pending_d;
      val_out          <= val_d;
      src_idx_out      <= show_idx_d;
      alert_active_out <= (state_d == ALERT);
      page_strobe_out  <= (state_d != IDLE) &&
                          ((state_d != state_q) || (show_idx_d != src_idx_out) || restart_d);
    end
  end

endmodule
